// File: rtl/int_accum_pkg.sv
// Shared definitions for the int_accum_sync block: dual-rail rail codes,
// FSM state encoding and dual-rail helper functions.
// The helpers work on a fixed maximum width (DR_MAX_W bits per word).
// Callers zero-extend narrower words; zero rails read as null.
package int_accum_pkg;

    typedef logic [1:0] rail_t;

    localparam rail_t RAIL_NULL = 2'b00;
    localparam rail_t RAIL_F    = 2'b01;
    localparam rail_t RAIL_T    = 2'b10;
    localparam rail_t RAIL_ILL  = 2'b11;

    localparam int unsigned DR_MAX_W = 64;

    typedef enum logic [1:0] {
        S_IN_WAIT = 2'b00,
        S_IN_ACK  = 2'b01,
        S_OUT_VAL = 2'b10,
        S_OUT_RTZ = 2'b11
    } state_t;

    // Single-rail word to dual-rail word: one rail pair per bit.
    function automatic logic [2*DR_MAX_W-1:0] dr_encode(input logic [DR_MAX_W-1:0] word);
        logic [2*DR_MAX_W-1:0] enc;
        enc = {(2*DR_MAX_W){1'b0}};
        for (int unsigned i = 0; i < DR_MAX_W; i++) begin
            if (word[i]) begin
                enc[2*i +: 2] = RAIL_T;
            end else begin
                enc[2*i +: 2] = RAIL_F;
            end
        end
        return enc;
    endfunction

    // True when each of the low nbits rail pairs carries a legal data code.
    function automatic logic dr_complete(input logic [2*DR_MAX_W-1:0] vec,
                                         input int unsigned nbits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DR_MAX_W; i++) begin
            if ((i < nbits) &&
                ((vec[2*i +: 2] == RAIL_NULL) || (vec[2*i +: 2] == RAIL_ILL))) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // True when every one of the low nbits rail pairs is null.
    function automatic logic dr_is_null(input logic [2*DR_MAX_W-1:0] vec,
                                        input int unsigned nbits);
        logic all_null;
        all_null = 1'b1;
        for (int unsigned i = 0; i < DR_MAX_W; i++) begin
            if ((i < nbits) && (vec[2*i +: 2] != RAIL_NULL)) begin
                all_null = 1'b0;
            end else begin
                all_null = all_null;
            end
        end
        return all_null;
    endfunction

    // True when any of the low nbits rail pairs carries the illegal code.
    function automatic logic dr_has_ill(input logic [2*DR_MAX_W-1:0] vec,
                                        input int unsigned nbits);
        logic ill;
        ill = 1'b0;
        for (int unsigned i = 0; i < DR_MAX_W; i++) begin
            if ((i < nbits) && (vec[2*i +: 2] == RAIL_ILL)) begin
                ill = 1'b1;
            end else begin
                ill = ill;
            end
        end
        return ill;
    endfunction

endpackage

// File: rtl/int_accum_sync_sync.sv
// Multi-bit flop-chain synchronizer, used on every incoming rail and on
// the consumer acknowledge. All stages clear to 0 (dual-rail null).
module dr_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/int_accum_sync.sv
// int_accum_sync: clocked multi-operand unsigned accumulator with dual-rail
// 4-phase return-to-zero channels on input and output.
// OPS operands are taken one per handshake. Each group yields one
// dual-rail sum plus a dual-rail overflow flag.
// Optional build macro INT_ACCUM_SAT_EN: the accumulator saturates to all
// ones on carry instead of wrapping.
// After reset the producer must show a genuine null before the next word is
// accepted, so a word left on the bus across reset is never captured.
module int_accum_sync
    import int_accum_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned OPS         = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0][1:0] a,
    output logic                  ack_o,
    input  logic                  ack_i,
    output logic [WIDTH-1:0][1:0] s,
    output logic [1:0]            c_out,
    output logic                  err
);

    localparam int unsigned CNT_W  = $clog2(OPS + 1);
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

    logic [2*WIDTH-1:0]    a_flat_s;
    logic [2*WIDTH-1:0]    a_sync_s;
    logic [2*WIDTH-1:0]    a_prev_r;
    logic [2*DR_MAX_W-1:0] a_wide_s;
    logic                  ack_i_sync_s;

    logic [WIDTH-1:0]      word_s;
    logic [WIDTH:0]        sum_s;
    logic [WIDTH-1:0]      acc_r;
    logic [WIDTH-1:0]      acc_nx_s;
    logic                  ovf_r;
    logic                  ovf_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nx_s;
    state_t                state_r;
    state_t                state_nx_s;
    logic                  armed_r;
    logic                  armed_nx_s;
    logic [WARM_W-1:0]     warm_r;
    logic                  warm_done_s;

    logic                  ill_s;
    logic                  null_s;
    logic                  complete_s;
    logic [2*DR_MAX_W-1:0] acc_enc_s;

    logic                  ack_o_r;
    logic [2*WIDTH-1:0]    s_r;
    rail_t                 c_out_r;
    logic                  err_r;

    assign a_flat_s = a;

    dr_sync #(.W(2*WIDTH), .STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst),
        .d     (a_flat_s),
        .q     (a_sync_s)
    );

    dr_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (clk),
        .rst_n (rst),
        .d     (ack_i),
        .q     (ack_i_sync_s)
    );

    // Word qualification: legal and unchanged over two samples, or fully null.
    assign a_wide_s    = (2*DR_MAX_W)'(a_sync_s);
    assign ill_s       = dr_has_ill(a_wide_s, WIDTH);
    assign null_s      = dr_is_null(a_wide_s, WIDTH);
    assign complete_s  = dr_complete(a_wide_s, WIDTH) && (a_sync_s == a_prev_r);
    assign warm_done_s = (warm_r == WARM_W'(SYNC_STAGES));
    assign acc_enc_s   = dr_encode(DR_MAX_W'(acc_r));

    if (WIDTH < DR_MAX_W) begin : g_pad
        logic enc_unused_s;
        assign enc_unused_s = ^acc_enc_s[2*DR_MAX_W-1:2*WIDTH];
    end

    // Recover the single-rail value from the true rails and form the sum.
    always_comb begin
        word_s = {WIDTH{1'b0}};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            word_s[i] = a_sync_s[2*i+1];
        end
        sum_s = {1'b0, acc_r} + {1'b0, word_s};
    end

    // Next-state and accumulator update for the handshake FSM.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        ovf_nx_s   = ovf_r;
        cnt_nx_s   = cnt_r;
        armed_nx_s = armed_r;
        case (state_r)
            S_IN_WAIT: begin
                if (complete_s && armed_r) begin
`ifdef INT_ACCUM_SAT_EN
                    acc_nx_s = sum_s[WIDTH] ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
`else
                    acc_nx_s = sum_s[WIDTH-1:0];
`endif
                    ovf_nx_s   = ovf_r | sum_s[WIDTH];
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    armed_nx_s = 1'b0;
                    state_nx_s = S_IN_ACK;
                end else if (null_s && warm_done_s) begin
                    armed_nx_s = 1'b1;
                end else begin
                    armed_nx_s = armed_r;
                end
            end
            S_IN_ACK: begin
                if (null_s) begin
                    armed_nx_s = 1'b1;
                    if (cnt_r == CNT_W'(OPS)) begin
                        state_nx_s = S_OUT_VAL;
                    end else begin
                        state_nx_s = S_IN_WAIT;
                    end
                end else begin
                    state_nx_s = S_IN_ACK;
                end
            end
            S_OUT_VAL: begin
                if (ack_i_sync_s) begin
                    state_nx_s = S_OUT_RTZ;
                end else begin
                    state_nx_s = S_OUT_VAL;
                end
            end
            S_OUT_RTZ: begin
                if (!ack_i_sync_s) begin
                    acc_nx_s   = {WIDTH{1'b0}};
                    ovf_nx_s   = 1'b0;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = S_IN_WAIT;
                end else begin
                    state_nx_s = S_OUT_RTZ;
                end
            end
            default: begin
                state_nx_s = S_IN_WAIT;
            end
        endcase
    end

    // FSM state, accumulator and arming registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IN_WAIT;
            acc_r   <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            ovf_r   <= ovf_nx_s;
            cnt_r   <= cnt_nx_s;
            armed_r <= armed_nx_s;
        end
    end

    // Previous-sample copy, post-reset warm-up count and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_prev_r <= {(2*WIDTH){1'b0}};
            warm_r   <= {WARM_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            a_prev_r <= a_sync_s;
            if (!warm_done_s) begin
                warm_r <= warm_r + WARM_W'(1);
            end else begin
                warm_r <= warm_r;
            end
            err_r <= err_r | ill_s;
        end
    end

    // Registered outputs decoded from the current state; whole words only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o_r <= 1'b0;
            s_r     <= {(2*WIDTH){1'b0}};
            c_out_r <= RAIL_NULL;
        end else begin
            ack_o_r <= (state_r == S_IN_ACK);
            if (state_r == S_OUT_VAL) begin
                s_r     <= acc_enc_s[2*WIDTH-1:0];
                c_out_r <= ovf_r ? RAIL_T : RAIL_F;
            end else begin
                s_r     <= {(2*WIDTH){1'b0}};
                c_out_r <= RAIL_NULL;
            end
        end
    end

    assign ack_o = ack_o_r;
    assign s     = s_r;
    assign c_out = c_out_r;
    assign err   = err_r;

endmodule
